// File: rtl/mem_pkg.sv
// Shared definitions for the cache-to-RAM arbiter: widths, FSM encoding and RAM command constants.
package mem_pkg;

  localparam int ADDR_W = 10;
  localparam int LINE_W = 20;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } arb_state_e;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: on a tie the port that did not win last time is chosen.
module rr_pick2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic valid_o,
  output logic winner_o
);

  always_comb begin
    valid_o  = req0_i | req1_i;
    winner_o = 1'b0;
    if (req0_i && req1_i) begin
      winner_o = ~last_grant_i;
    end else if (req1_i) begin
      winner_o = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM between the instruction cache (port 0) and data cache (port 1):
// round-robin grant, one transaction in flight, optional watchdog abort.
module mem_arbiter #(
  parameter int ADDR_W  = mem_pkg::ADDR_W,
  parameter int LINE_W  = mem_pkg::LINE_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [LINE_W-1:0] wdata0,
  input  logic [LINE_W-1:0] wdata1,
  output logic [LINE_W-1:0] rdata0,
  output logic [LINE_W-1:0] rdata1,
  output logic              ready0,
  output logic              ready1,
  output logic              err0,
  output logic              err1,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        dbg_state
);
  import mem_pkg::*;

  // The counter only needs to reach TIMEOUT-1; with the watchdog off it just wraps.
  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic             WD_EN    = (TIMEOUT != 0);

  arb_state_e        state_q;
  logic              last_q, gnt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mem_req_q, mem_rw_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q, rdata0_q, rdata1_q, cap_line;
  logic [1:0]        ready_q, err_q;
  logic              pick_valid, pick_winner;

  rr_pick2 u_pick (
    .req0_i       (req0),
    .req1_i       (req1),
    .last_grant_i (last_q),
    .valid_o      (pick_valid),
    .winner_o     (pick_winner)
  );

  assign cap_line = (mem_rw_q == MEM_WRITE) ? '0 : mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      ready_q     <= 2'b00;
      err_q       <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            gnt_q       <= pick_winner;
            last_q      <= pick_winner;
            cnt_q       <= '0;
            mem_req_q   <= 1'b1;
            mem_rw_q    <= pick_winner ? rw1 : rw0;
            mem_addr_q  <= pick_winner ? addr1 : addr0;
            mem_wdata_q <= pick_winner ? wdata1 : wdata0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          // A completion in the same cycle as the deadline still counts as success.
          if (mem_ready) begin
            if (gnt_q) rdata1_q <= cap_line;
            else       rdata0_q <= cap_line;
            mem_req_q      <= 1'b0;
            ready_q[gnt_q] <= 1'b1;
            err_q[gnt_q]   <= 1'b0;
            state_q        <= DONE;
          end else if (WD_EN && cnt_q == CNT_LAST) begin
            if (gnt_q) rdata1_q <= '0;
            else       rdata0_q <= '0;
            mem_req_q      <= 1'b0;
            ready_q[gnt_q] <= 1'b1;
            err_q[gnt_q]   <= 1'b1;
            state_q        <= DONE;
          end
        end
        DONE: begin
          ready_q <= 2'b00;
          err_q   <= 2'b00;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign ready0    = ready_q[0];
  assign ready1    = ready_q[1];
  assign err0      = err_q[0];
  assign err1      = err_q[1];
  assign mem_req   = mem_req_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (watchdog 4 and watchdog off) checked every cycle
// against a transaction-level model of grants, latencies and completions.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int T0 = 4;
  localparam int T1 = 0;

  // Handshake: a requester holds req and its fields until the cycle its ready pulse is seen;
  // the RAM side answers with a single-cycle mem_ready, ignored by the arbiter outside BUSY.

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]          rst, req0, req1, rw0, rw1, mem_ready;
  logic [2*ADDR_W-1:0] addr0, addr1;
  logic [2*LINE_W-1:0] wdata0, wdata1, mem_rdata;
  wire  [2*LINE_W-1:0] rdata0, rdata1, mem_wdata;
  wire  [1:0]          ready0, ready1, err0, err1, mem_req, mem_rw;
  wire  [2*ADDR_W-1:0] mem_addr;
  wire  [3:0]          dbg_state;

  mem_arbiter #(.TIMEOUT(T0)) dut_wd (
    .clk(clk), .rst(rst[0]),
    .req0(req0[0]), .req1(req1[0]), .rw0(rw0[0]), .rw1(rw1[0]),
    .addr0(addr0[ADDR_W-1:0]), .addr1(addr1[ADDR_W-1:0]),
    .wdata0(wdata0[LINE_W-1:0]), .wdata1(wdata1[LINE_W-1:0]),
    .rdata0(rdata0[LINE_W-1:0]), .rdata1(rdata1[LINE_W-1:0]),
    .ready0(ready0[0]), .ready1(ready1[0]), .err0(err0[0]), .err1(err1[0]),
    .mem_req(mem_req[0]), .mem_rw(mem_rw[0]),
    .mem_addr(mem_addr[ADDR_W-1:0]), .mem_wdata(mem_wdata[LINE_W-1:0]),
    .mem_rdata(mem_rdata[LINE_W-1:0]), .mem_ready(mem_ready[0]),
    .dbg_state(dbg_state[1:0])
  );

  mem_arbiter #(.TIMEOUT(T1)) dut_nowd (
    .clk(clk), .rst(rst[1]),
    .req0(req0[1]), .req1(req1[1]), .rw0(rw0[1]), .rw1(rw1[1]),
    .addr0(addr0[2*ADDR_W-1:ADDR_W]), .addr1(addr1[2*ADDR_W-1:ADDR_W]),
    .wdata0(wdata0[2*LINE_W-1:LINE_W]), .wdata1(wdata1[2*LINE_W-1:LINE_W]),
    .rdata0(rdata0[2*LINE_W-1:LINE_W]), .rdata1(rdata1[2*LINE_W-1:LINE_W]),
    .ready0(ready0[1]), .ready1(ready1[1]), .err0(err0[1]), .err1(err1[1]),
    .mem_req(mem_req[1]), .mem_rw(mem_rw[1]),
    .mem_addr(mem_addr[2*ADDR_W-1:ADDR_W]), .mem_wdata(mem_wdata[2*LINE_W-1:LINE_W]),
    .mem_rdata(mem_rdata[2*LINE_W-1:LINE_W]), .mem_ready(mem_ready[1]),
    .dbg_state(dbg_state[3:2])
  );

  // ---------------- reference model state ----------------
  int                tot = 0, bad = 0, cyc = 0;
  int                tmo [2] = '{T0, T1};
  bit                m_busy [2], m_port [2], m_rw [2], m_ok [2], m_last [2], auto_on [2];
  logic [ADDR_W-1:0] m_addr [2];
  logic [LINE_W-1:0] m_wd [2], m_data [2], exp_rd0 [2], exp_rd1 [2], next_data [2];
  bit                use_next_data [2];
  int                m_start [2], m_lat [2], m_done [2], m_idle_at [2], next_lat [2];
  int                keep [2][2];
  logic [0:0]        exp_q [$];

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    tot++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s inst%0d cyc%0d observed=%0h expected=%0h", tag, i, cyc, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic get_req(input int i, input int p);
    return (p == 0) ? req0[i] : req1[i];
  endfunction

  task automatic drive_port(input int i, input int p, input logic r, input logic w,
                            input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
    if (p == 0) begin
      req0[i] = r; rw0[i] = w; addr0[i*ADDR_W +: ADDR_W] = a; wdata0[i*LINE_W +: LINE_W] = d;
    end else begin
      req1[i] = r; rw1[i] = w; addr1[i*ADDR_W +: ADDR_W] = a; wdata1[i*LINE_W +: LINE_W] = d;
    end
  endtask

  task automatic new_req(input int i, input int p);
    drive_port(i, p, 1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom), LINE_W'($urandom));
  endtask

  task automatic drop_req(input int i, input int p);
    if (p == 0) req0[i] = 1'b0;
    else        req1[i] = 1'b0;
  endtask

  // One clock: observe just after the edge, advance the model, then drive the next inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      bit                done_now, w;
      logic [1:0]        exp_r, exp_e;
      logic [LINE_W-1:0] line;
      done_now = 1'b0;
      if (rst[i]) begin
        m_busy[i] = 1'b0; m_last[i] = 1'b1; m_idle_at[i] = cyc + 1;
        exp_rd0[i] = '0; exp_rd1[i] = '0;
        chk("rst_mem_req", i, mem_req[i], 0);
        chk("rst_mem_rw", i, mem_rw[i], 0);
        chk("rst_mem_addr", i, mem_addr[i*ADDR_W +: ADDR_W], 0);
        chk("rst_mem_wdata", i, mem_wdata[i*LINE_W +: LINE_W], 0);
        chk("rst_ready", i, {ready1[i], ready0[i]}, 0);
        chk("rst_err", i, {err1[i], err0[i]}, 0);
        chk("rst_rdata0", i, rdata0[i*LINE_W +: LINE_W], 0);
        chk("rst_rdata1", i, rdata1[i*LINE_W +: LINE_W], 0);
        chk("rst_state", i, dbg_state[2*i +: 2], IDLE);
      end else begin
        exp_r = 2'b00;
        exp_e = 2'b00;
        if (m_busy[i] && cyc == m_done[i]) begin
          done_now = 1'b1;
          m_busy[i] = 1'b0;
          m_idle_at[i] = cyc + 2;
          line = (m_ok[i] && m_rw[i] == MEM_READ) ? m_data[i] : '0;
          if (m_port[i]) exp_rd1[i] = line;
          else           exp_rd0[i] = line;
          exp_r[m_port[i]] = 1'b1;
          exp_e[m_port[i]] = !m_ok[i];
        end
        chk("ready", i, {ready1[i], ready0[i]}, exp_r);
        chk("err", i, {err1[i], err0[i]}, exp_e);
        chk("rdata0", i, rdata0[i*LINE_W +: LINE_W], exp_rd0[i]);
        chk("rdata1", i, rdata1[i*LINE_W +: LINE_W], exp_rd1[i]);
        if (!m_busy[i] && !done_now && cyc >= m_idle_at[i] && (req0[i] || req1[i])) begin
          w = (req0[i] && req1[i]) ? !m_last[i] : req1[i];
          m_last[i]  = w;
          m_port[i]  = w;
          m_busy[i]  = 1'b1;
          m_rw[i]    = w ? rw1[i] : rw0[i];
          m_addr[i]  = w ? addr1[i*ADDR_W +: ADDR_W] : addr0[i*ADDR_W +: ADDR_W];
          m_wd[i]    = w ? wdata1[i*LINE_W +: LINE_W] : wdata0[i*LINE_W +: LINE_W];
          m_start[i] = cyc;
          m_lat[i]   = (next_lat[i] >= 0) ? next_lat[i] : $urandom_range(0, 6);
          next_lat[i] = -1;
          m_ok[i]    = (tmo[i] == 0) || (m_lat[i] < tmo[i]);
          m_done[i]  = cyc + 1 + (m_ok[i] ? m_lat[i] : tmo[i] - 1);
          m_data[i]  = use_next_data[i] ? next_data[i] : LINE_W'($urandom);
          use_next_data[i] = 1'b0;
          if (i == 0 && exp_q.size() > 0) chk("grant_order", i, w, exp_q.pop_front());
        end
        if (m_busy[i]) begin
          chk("mem_req", i, mem_req[i], 1);
          chk("mem_rw", i, mem_rw[i], m_rw[i]);
          chk("mem_addr", i, mem_addr[i*ADDR_W +: ADDR_W], m_addr[i]);
          chk("mem_wdata", i, mem_wdata[i*LINE_W +: LINE_W], m_wd[i]);
          chk("state", i, dbg_state[2*i +: 2], BUSY);
        end else begin
          chk("mem_req", i, mem_req[i], 0);
          chk("state", i, dbg_state[2*i +: 2], done_now ? DONE : IDLE);
        end
      end
      // RAM side: answer exactly m_lat cycles into BUSY; stray mem_ready outside BUSY
      if (m_busy[i] && m_ok[i] && cyc == m_start[i] + m_lat[i]) begin
        mem_ready[i] = 1'b1;
        mem_rdata[i*LINE_W +: LINE_W] = m_data[i];
      end else begin
        mem_ready[i] = (!m_busy[i] && auto_on[i]) ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata[i*LINE_W +: LINE_W] = LINE_W'($urandom);
      end
      for (int p = 0; p < 2; p++) begin
        if (done_now && m_port[i] == p) begin
          if (keep[i][p] > 0) begin
            keep[i][p]--;
            new_req(i, p);
          end else if (auto_on[i] && $urandom_range(0, 1) == 1) begin
            new_req(i, p);
          end else begin
            drop_req(i, p);
          end
        end else if (!get_req(i, p) && auto_on[i] && $urandom_range(0, 3) == 0) begin
          new_req(i, p);
        end
      end
    end
  endtask

  task automatic wait_idle(input int i, input int limit);
    int n;
    n = 0;
    while ((m_busy[i] || req0[i] || req1[i]) && n < limit) begin
      tick();
      n++;
    end
    tot++;
    assert (n < limit) else begin
      bad++;
      $error("FAIL drain_budget inst%0d observed=%0d cycles expected below %0d", i, n, limit);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 2'b11; req0 = '0; req1 = '0; rw0 = '0; rw1 = '0; mem_ready = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_last[i] = 1'b1; auto_on[i] = 1'b0; next_lat[i] = -1;
      use_next_data[i] = 1'b0; m_idle_at[i] = 0; exp_rd0[i] = '0; exp_rd1[i] = '0;
      keep[i][0] = 0; keep[i][1] = 0;
    end
    tick();
    tick();
    rst = 2'b00;

    // single read, RAM answers after 2 cycles
    next_lat[0] = 2; next_data[0] = 20'hABCDE; use_next_data[0] = 1'b1;
    drive_port(0, 0, 1'b1, MEM_READ, 10'd50, '0);
    wait_idle(0, 50);
    chk("single_read_rdata0", 0, rdata0[LINE_W-1:0], 20'hABCDE);

    // simultaneous requests straight after reset: port 0 first, then the write on port 1
    rst = 2'b01; tick(); rst = 2'b00;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    drive_port(0, 0, 1'b1, MEM_READ, 10'd84, LINE_W'($urandom));
    drive_port(0, 1, 1'b1, MEM_WRITE, 10'd223, 20'd500);
    wait_idle(0, 100);
    chk("simul_order_drained", 0, exp_q.size(), 0);

    // fairness: both ports keep reissuing for six transactions
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    end
    keep[0][0] = 2; keep[0][1] = 2;
    new_req(0, 0); new_req(0, 1);
    wait_idle(0, 200);
    chk("fair_order_drained", 0, exp_q.size(), 0);

    // watchdog abort on a read that never completes
    next_lat[0] = 1000;
    drive_port(0, 1, 1'b1, MEM_READ, 10'd17, '0);
    wait_idle(0, 50);
    chk("watchdog_rdata1", 0, rdata1[LINE_W-1:0], 0);

    // completion on the deadline cycle beats the watchdog
    next_lat[0] = T0 - 1;
    drive_port(0, 0, 1'b1, MEM_READ, 10'd300, '0);
    wait_idle(0, 50);

    // watchdog disabled: 40-cycle RAM latency still completes normally
    next_lat[1] = 40;
    drive_port(1, 0, 1'b1, MEM_READ, 10'd99, '0);
    wait_idle(1, 100);

    // reset in the middle of a port-0 read; port 0 wins again afterwards
    rst = 2'b01; tick(); rst = 2'b00;
    next_lat[0] = 10;
    new_req(0, 0); new_req(0, 1);
    tick(); tick(); tick();
    rst = 2'b01; tick(); rst = 2'b00;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    wait_idle(0, 100);
    chk("post_reset_order_drained", 0, exp_q.size(), 0);

    // random traffic on both instances
    auto_on[0] = 1'b1; auto_on[1] = 1'b1;
    for (int n = 0; n < 3000; n++) tick();
    auto_on[0] = 1'b0; auto_on[1] = 1'b0;
    wait_idle(0, 200);
    wait_idle(1, 200);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
